// File: rtl/nco_pkg.sv
// Shared definitions for the quadrature NCO: quadrant encoding,
// dither LFSR seed/taps, pipeline latency and small fold helpers.
package nco_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int NCO_LATENCY = 3;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Odd quadrants walk the quarter table backwards.
    function automatic logic fold_mirror(input quad_e q);
        logic m;
        m = 1'b0;
        unique case (1'b1)
            (q == QUAD_1), (q == QUAD_3): m = 1'b1;
            default:                      m = 1'b0;
        endcase
        return m;
    endfunction

    // Lower half-plane quadrants negate the table entry.
    function automatic logic fold_negate(input quad_e q);
        logic n;
        n = 1'b0;
        unique case (1'b1)
            (q == QUAD_2), (q == QUAD_3): n = 1'b1;
            default:                      n = 1'b0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Quarter-wave sine magnitude table, two registered read ports.
// Ports: ip_clock, ip_reset (async, active-low), ip_sin_idx/ip_cos_idx
// read addresses, op_sin_mag/op_cos_mag registered magnitudes.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 12
) (
    input  logic              ip_clock,
    input  logic              ip_reset,
    input  logic [LUT_AW-1:0] ip_sin_idx,
    input  logic [LUT_AW-1:0] ip_cos_idx,
    output logic [OUT_W-2:0]  op_sin_mag,
    output logic [OUT_W-2:0]  op_cos_mag
);

    localparam int N = 1 << LUT_AW;

    // Half-step offset keeps mirrored entries exact and never
    // reaches full scale, so negation cannot overflow.
    function automatic logic [OUT_W-2:0] entry(input int k);
        real a;
        real x;
        a = real'((1 << (OUT_W - 1)) - 1);
        x = a * $sin(3.14159265358979 / 2.0
                     * (real'(k) + 0.5) / real'(N));
        return (OUT_W-1)'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-2:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        assign rom[k] = entry(k);
    end

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            op_sin_mag <= '0;
            op_cos_mag <= '0;
        end else begin
            op_sin_mag <= rom[ip_sin_idx];
            op_cos_mag <= rom[ip_cos_idx];
        end
    end

endmodule

// File: rtl/nco_quad_gen.sv
// Quadrature NCO: phase accumulator, quadrant fold, quarter-wave LUT.
// Ports: ip_clock, ip_reset (async, active-low), ip_enable, ip_fcw,
// ip_fcw_load, ip_phase_offset, ip_phase_clear; op_valid,
// op_sine_wave, op_cosine_wave, op_wrap. Three-stage pipeline.
// Build option NCO_DITHER_EN adds LFSR phase dither before truncation.
module nco_quad_gen
    import nco_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 12
) (
    input  logic                     ip_clock,
    input  logic                     ip_reset,
    input  logic                     ip_enable,
    input  logic [PHASE_W-1:0]       ip_fcw,
    input  logic                     ip_fcw_load,
    input  logic [PHASE_W-1:0]       ip_phase_offset,
    input  logic                     ip_phase_clear,
    output logic                     op_valid,
    output logic signed [OUT_W-1:0]  op_sine_wave,
    output logic signed [OUT_W-1:0]  op_cosine_wave,
    output logic                     op_wrap
);

    localparam int TRUNC_W = PHASE_W - 2 - LUT_AW;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] fcw_reg;
    logic               wrap_pend;
    logic [PHASE_W:0]   acc_sum;
    logic [PHASE_W-1:0] phase;

    assign acc_sum = {1'b0, acc} + {1'b0, fcw_reg};

`ifdef NCO_DITHER_EN
    localparam int DW = (TRUNC_W < 16) ? TRUNC_W : 16;

    logic [15:0] lfsr;

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            lfsr <= LFSR_SEED;
        end else if (ip_enable) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign phase = acc + ip_phase_offset + PHASE_W'(lfsr[DW-1:0]);
`else
    assign phase = acc + ip_phase_offset;
`endif

    logic [TRUNC_W-1:0] unused_phase;
    assign unused_phase = phase[TRUNC_W-1:0];

    // Clear wins over accumulate; the sample launched this cycle
    // has already used the pre-clear accumulator.
    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            acc       <= '0;
            fcw_reg   <= '0;
            wrap_pend <= 1'b0;
        end else begin
            if (ip_fcw_load) begin
                fcw_reg <= ip_fcw;
            end
            if (ip_phase_clear) begin
                acc       <= '0;
                wrap_pend <= 1'b0;
            end else if (ip_enable) begin
                acc       <= acc_sum[PHASE_W-1:0];
                wrap_pend <= acc_sum[PHASE_W];
            end
        end
    end

    quad_e             sin_q;
    quad_e             cos_q;
    logic [LUT_AW-1:0] idx;

    assign sin_q = quad_e'(phase[PHASE_W-1 -: 2]);
    assign cos_q = quad_e'(2'(phase[PHASE_W-1 -: 2] + 2'd1));
    assign idx   = phase[PHASE_W-3 -: LUT_AW];

    logic [NCO_LATENCY-1:0] vld_pipe;
    logic [NCO_LATENCY-1:0] wrap_pipe;

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            vld_pipe  <= '0;
            wrap_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[NCO_LATENCY-2:0], ip_enable};
            wrap_pipe <= {wrap_pipe[NCO_LATENCY-2:0],
                          ip_enable & wrap_pend};
        end
    end

    // S1: folded table indices and sign flags
    logic [LUT_AW-1:0] s1_sin_idx;
    logic [LUT_AW-1:0] s1_cos_idx;
    logic              s1_sin_neg;
    logic              s1_cos_neg;
    logic              s2_sin_neg;
    logic              s2_cos_neg;

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            s1_sin_idx <= '0;
            s1_cos_idx <= '0;
            s1_sin_neg <= 1'b0;
            s1_cos_neg <= 1'b0;
            s2_sin_neg <= 1'b0;
            s2_cos_neg <= 1'b0;
        end else begin
            // N-1-idx is the bitwise complement of idx
            s1_sin_idx <= fold_mirror(sin_q) ? ~idx : idx;
            s1_cos_idx <= fold_mirror(cos_q) ? ~idx : idx;
            s1_sin_neg <= fold_negate(sin_q);
            s1_cos_neg <= fold_negate(cos_q);
            s2_sin_neg <= s1_sin_neg;
            s2_cos_neg <= s1_cos_neg;
        end
    end

    // S2: table read
    logic [OUT_W-2:0] sin_mag;
    logic [OUT_W-2:0] cos_mag;

    nco_quarter_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .ip_clock   (ip_clock),
        .ip_reset   (ip_reset),
        .ip_sin_idx (s1_sin_idx),
        .ip_cos_idx (s1_cos_idx),
        .op_sin_mag (sin_mag),
        .op_cos_mag (cos_mag)
    );

    // S3: sign application; outputs hold between valid samples
    logic signed [OUT_W-1:0] sin_pos;
    logic signed [OUT_W-1:0] cos_pos;

    assign sin_pos = {1'b0, sin_mag};
    assign cos_pos = {1'b0, cos_mag};

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            op_sine_wave   <= '0;
            op_cosine_wave <= '0;
        end else if (vld_pipe[NCO_LATENCY-2]) begin
            op_sine_wave   <= s2_sin_neg ? -sin_pos : sin_pos;
            op_cosine_wave <= s2_cos_neg ? -cos_pos : cos_pos;
        end
    end

    assign op_valid = vld_pipe[NCO_LATENCY-1];
    assign op_wrap  = wrap_pipe[NCO_LATENCY-1];

endmodule

// File: tb/tb_nco_quad_gen.sv
// Self-checking bench for nco_quad_gen, default parameters.
// Directed vectors with hand-computed sine/cosine values.
module tb_nco_quad_gen;

    logic               ip_clock = 1'b0;
    logic               ip_reset = 1'b0;
    logic               ip_enable = 1'b0;
    logic [31:0]        ip_fcw = '0;
    logic               ip_fcw_load = 1'b0;
    logic [31:0]        ip_phase_offset = '0;
    logic               ip_phase_clear = 1'b0;
    logic               op_valid;
    logic signed [11:0] op_sine_wave;
    logic signed [11:0] op_cosine_wave;
    logic               op_wrap;

    int errors = 0;
    int checks = 0;

    nco_quad_gen dut (
        .ip_clock        (ip_clock),
        .ip_reset        (ip_reset),
        .ip_enable       (ip_enable),
        .ip_fcw          (ip_fcw),
        .ip_fcw_load     (ip_fcw_load),
        .ip_phase_offset (ip_phase_offset),
        .ip_phase_clear  (ip_phase_clear),
        .op_valid        (op_valid),
        .op_sine_wave    (op_sine_wave),
        .op_cosine_wave  (op_cosine_wave),
        .op_wrap         (op_wrap)
    );

    always #5 ip_clock = ~ip_clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ip_clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    int sin_q [4] = '{6, 2047, -6, -2047};
    int cos_q [4] = '{2047, -6, -2047, 6};

    initial begin
        int s;
        int c;
        int pw;
        int n;
        bit en_hist [16];
        int seq_a [20];
        bit diff;

        #12;
        check("rst_valid", op_valid, 0);
        check("rst_sin", op_sine_wave, 0);
        check("rst_cos", op_cosine_wave, 0);
        check("rst_wrap", op_wrap, 0);
        ip_reset = 1'b1;
        tick();

`ifndef NCO_DITHER_EN
        // fcw=0, offset=0: constant phase 0
        ip_fcw = 32'h0;
        ip_fcw_load = 1'b1;
        ip_enable = 1'b1;
        tick();
        ip_fcw_load = 1'b0;
        tick();
        check("lat_early", op_valid, 0);
        tick();
        check("lat_valid", op_valid, 1);
        check("p0_sin", op_sine_wave, 6);
        check("p0_cos", op_cosine_wave, 2047);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p0_hold_sin", op_sine_wave, 6);
            check("p0_hold_cos", op_cosine_wave, 2047);
        end

        ip_phase_offset = 32'h8000_0000;
        repeat (3) tick();
        check("off180_sin", op_sine_wave, -6);
        check("off180_cos", op_cosine_wave, -2047);
        ip_phase_offset = 32'h4000_0000;
        repeat (3) tick();
        check("off90_sin", op_sine_wave, 2047);
        check("off90_cos", op_cosine_wave, -6);

        // quarter-turn step with clear
        ip_phase_offset = 32'h0;
        ip_fcw = 32'h4000_0000;
        ip_fcw_load = 1'b1;
        ip_phase_clear = 1'b1;
        tick();
        ip_fcw_load = 1'b0;
        ip_phase_clear = 1'b0;
        tick();
        tick();
        check("q_l0_sin", op_sine_wave, 6);
        check("q_l0_wrap", op_wrap, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("q_valid", op_valid, 1);
            check("q_sin", op_sine_wave, sin_q[(k-1)%4]);
            check("q_cos", op_cosine_wave, cos_q[(k-1)%4]);
            check("q_wrap", op_wrap, (k == 5 || k == 9) ? 1 : 0);
        end

        // load with clear while running
        ip_fcw = 32'h1000_0000;
        ip_fcw_load = 1'b1;
        ip_phase_clear = 1'b1;
        tick();
        ip_fcw_load = 1'b0;
        ip_phase_clear = 1'b0;
        tick();
        tick();
        tick();
        check("lc0_sin", op_sine_wave, 6);
        check("lc0_cos", op_cosine_wave, 2047);
        tick();
        check("lc1_sin", op_sine_wave, 789);
        check("lc1_cos", op_cosine_wave, 1889);
        tick();
        check("lc2_sin", op_sine_wave, 1452);
        check("lc2_cos", op_cosine_wave, 1443);

        // amplitude sanity over random phases
        ip_fcw = $urandom;
        ip_fcw_load = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ip_phase_offset = $urandom;
            tick();
            ip_fcw_load = 1'b0;
            s = op_sine_wave;
            c = op_cosine_wave;
            pw = s * s + c * c;
            check("rnd_range",
                  (s <= 2047 && s >= -2047 &&
                   c <= 2047 && c >= -2047) ? 1 : 0, 1);
            check("rnd_power",
                  (pw >= 4148307 && pw <= 4232111) ? 1 : 0, 1);
        end

        // 1-on/2-off enable pattern
        ip_phase_offset = 32'h0;
        ip_enable = 1'b0;
        ip_fcw = 32'h4000_0000;
        ip_fcw_load = 1'b1;
        ip_phase_clear = 1'b1;
        tick();
        ip_fcw_load = 1'b0;
        ip_phase_clear = 1'b0;
        repeat (3) tick();
        check("drain_valid", op_valid, 0);
        n = 0;
        for (int i = 0; i < 14; i++) begin
            en_hist[i] = (i % 3 == 0) && (i < 12);
            ip_enable = en_hist[i];
            tick();
            check("pat_valid", op_valid,
                  (i >= 2) ? int'(en_hist[i-2]) : 0);
            if (i >= 2 && en_hist[i-2]) begin
                check("pat_sin", op_sine_wave, sin_q[n % 4]);
                n++;
            end
        end
        check("pat_count", n, 4);
`else
        // dither: repeatable after reset, differs from undithered
        ip_phase_offset = 32'h003F_FFF0;
        ip_enable = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            seq_a[i] = op_sine_wave;
        end
        ip_enable = 1'b0;
        #2 ip_reset = 1'b0;
        #5 ip_reset = 1'b1;
        tick();
        ip_enable = 1'b1;
        tick();
        tick();
        diff = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("dith_repeat", op_sine_wave, seq_a[i]);
            if (op_sine_wave != 6) diff = 1'b1;
        end
        check("dith_differs", diff, 1);
`endif

        // asynchronous reset mid-stream
        ip_enable = 1'b1;
        repeat (5) tick();
        #2 ip_reset = 1'b0;
        #1;
        check("mid_rst_valid", op_valid, 0);
        check("mid_rst_sin", op_sine_wave, 0);
        check("mid_rst_cos", op_cosine_wave, 0);
        check("mid_rst_wrap", op_wrap, 0);
        ip_enable = 1'b0;
        ip_reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_quad_gen.md
# nco_quad_gen

Parametrised quadrature numerically controlled oscillator. Generates signed sine and cosine samples from a programmable phase accumulator. A quarter-wave lookup table with quadrant folding produces the waveform. Sits in the modulator/demodulator datapath wherever a fixed-phase sine/cosine generator was used. Adds programmable frequency, phase offset, wrap indication and optional phase dither.

## Interface
- PHASE_W, 32, accumulator and frequency-control-word width
- LUT_AW, 8, quarter-wave table address width (2^LUT_AW entries)
- OUT_W, 12, signed output sample width
- ip_clock  in  1  clock
- ip_reset  in  1  reset, asynchronous, active-low
- ip_enable  in  1  advance accumulator and launch one sample this cycle
- ip_fcw  in  PHASE_W  frequency control word (unsigned phase increment)
- ip_fcw_load  in  1  capture ip_fcw into the internal FCW register
- ip_phase_offset  in  PHASE_W  phase offset added to the accumulator before lookup (sampled per launched sample)
- ip_phase_clear  in  1  synchronous clear of accumulator to 0
- op_valid  out  1  sample on op_sine_wave/op_cosine_wave is new this cycle
- op_sine_wave  out  OUT_W signed  sine sample
- op_cosine_wave  out  OUT_W signed  cosine sample
- op_wrap  out  1  sample is the first after an accumulator carry-out (aligned with op_valid)

## Operation
- Reset (ip_reset low): accumulator, FCW register, pipeline, all outputs = 0; op_valid = 0, op_wrap = 0.
- ip_fcw_load high: fcw_reg <= ip_fcw. The new value is used on the first enabled cycle after the load cycle.
- Enabled cycle: launch sample with phase p = acc + ip_phase_offset (mod 2^PHASE_W). Then acc <= acc + fcw_reg (mod 2^PHASE_W), with carry-out recorded as the wrap flag for the *next* launched sample.
- ip_phase_clear: acc <= 0, and the pending wrap flag is cleared. It overrides accumulate when coincident with ip_enable. The sample launched that cycle still uses the pre-clear acc. It may coincide with ip_fcw_load; both take effect.
- Lookup address: q = p[PHASE_W-1:PHASE_W-2]; idx = p[PHASE_W-3 -: LUT_AW]. Lower bits are truncated.
- Table: L[k] = round(A·sin(π/2·(k+0.5)/2^LUT_AW)), A = 2^(OUT_W-1)-1. The half-step offset makes folding exact; no -2^(OUT_W-1) is ever produced.
- Sine fold:
  - q=0: +L[idx]
  - q=1: +L[N-1-idx]
  - q=2: -L[idx]
  - q=3: -L[N-1-idx]
- Cosine uses the same fold with quadrant q+1 (mod 4) and the same idx.
- When ip_enable is low, no sample launches; the accumulator holds. In-flight samples drain normally. Outputs hold their last value while op_valid = 0.

## Timing
- Pipeline stages:
  - S1: phase add/fold register
  - S2: LUT read register
  - S3: negate/output register
- Latency: ip_enable high at edge t → op_valid high after edge t+3, with that sample's values. Throughput is 1 sample/cycle.
- op_wrap travels with its sample through all three stages.
- Reset mid-operation flushes all stages immediately; op_valid falls asynchronously.

## Configuration
- NCO_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances on each enabled cycle.
  - Its low (PHASE_W-2-LUT_AW) bits (or all 16 if fewer) are added to p before truncation, which spreads truncation spurs.
  - The LFSR resets to the seed.
- Not defined: no LFSR; p is truncated directly. Outputs are bit-exact to the table equations above.

## Structure
- Package nco_pkg:
  - quadrant encoding constants
  - LFSR seed and tap mask
  - latency constant NCO_LATENCY = 3
- Sub-module nco_quarter_lut: registered read of one table entry per port, dual read port (sine and cosine indices), table generated from LUT_AW/OUT_W at elaboration.

## Test plan
All cases use default parameters, with NCO_DITHER_EN undefined unless stated.
- Reset, then fcw=0 loaded, offset=0, enable held: every valid sample sin=+6, cos=+2047; op_valid first high 3 cycles after enable.
- offset=0x8000_0000, fcw=0: sin=-6, cos=-2047; offset=0x4000_0000: sin=+2047, cos=-6.
- fcw=0x4000_0000: outputs cycle through (sin,cos) = (6,2047), (2047,-6), (-6,-2047), (-2047,6). op_wrap high on every 4th valid sample, starting with the 5th.
- Load fcw=0x1000_0000 while running, with ip_phase_clear in the same cycle: the next launched sample has phase 0, and the step after it is 0x1000_0000. A check across 100 random cycles confirms |sin|,|cos| ≤ 2047 and sin²+cos² is within 1% of 2047².
- Toggle ip_enable in a 1-on/2-off pattern: op_valid reproduces the pattern delayed by 3, and the accumulator advances only on enabled cycles.
- Assert reset mid-stream: all outputs and op_valid are 0 immediately. With NCO_DITHER_EN, the sample sequence is repeatable after reset and differs from the undithered sequence.
